// File: rtl/collatz_pkg.sv
// Shared constants for the Collatz orbit engine: register map regions,
// status bit positions and FSM state encodings.
package collatz_pkg;

  localparam logic [1:0] REG_ITER = 2'b00;
  localparam logic [1:0] REG_PEAK = 2'b01;
  localparam logic [1:0] REG_OLEN = 2'b10;
  localparam logic [1:0] REG_STAT = 2'b11;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_LIMIT = 3;
  localparam int ST_ABORT = 4;
  localparam int ST_ZERO  = 5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/collatz_step.sv
// One Collatz step: computes the successor of n, the orbit-length increment
// and whether 3n+1 no longer fits in WIDTH bits.
module collatz_step #(
  parameter int WIDTH    = 144,
  parameter int SHORTCUT = 0
) (
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] next,
  output logic [1:0]       incr,
  output logic             ovf
);

  logic [WIDTH+1:0] triple;

  // 3n+1 is formed at WIDTH+2 bits so the overflow test sees every carry,
  // even in shortcut mode where only the halved value is kept.
  always_comb begin
    triple = {2'b00, n} + {1'b0, n, 1'b0} + (WIDTH+2)'(1);
    ovf    = n[0] & (|triple[WIDTH+1:WIDTH]);
    if (!n[0]) begin
      next = n >> 1;
      incr = 2'd1;
    end else if (SHORTCUT != 0) begin
      next = triple[WIDTH:1];
      incr = 2'd2;
    end else begin
      next = triple[WIDTH-1:0];
      incr = 2'd1;
    end
  end

endmodule

// File: rtl/collatz_orbit_engine.sv
// Collatz orbit engine: byte-addressed seed load, iterate to 1 on start,
// report orbit length, path peak and a status byte.
module collatz_orbit_engine
  import collatz_pkg::*;
#(
  parameter int WIDTH    = 144,
  parameter int OLEN_W   = 16,
  parameter int SHORTCUT = 0,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              abort,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NBYTES = WIDTH / 8;
  localparam int OBYTES = OLEN_W / 8;

  state_t            state;
  logic [WIDTH-1:0]  iter;
  logic [WIDTH-1:0]  peak;
  logic [OLEN_W-1:0] olen;
  logic              ovf_flag;
  logic              limit_flag;
  logic              abort_flag;
  logic              zero_flag;

  logic [WIDTH-1:0]  step_next;
  logic [1:0]        step_incr;
  logic              step_ovf;
  logic [OLEN_W:0]   olen_sum;
  logic [1:0]        region;
  int unsigned       idx;
  logic [7:0]        status_byte;
  logic [7:0]        rd_next;

  collatz_step #(
    .WIDTH    (WIDTH),
    .SHORTCUT (SHORTCUT)
  ) u_step (
    .n    (iter),
    .next (step_next),
    .incr (step_incr),
    .ovf  (step_ovf)
  );

  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign error       = ovf_flag | limit_flag | abort_flag | zero_flag;
  assign region      = addr[ADDR_W-1:ADDR_W-2];
  assign idx         = 32'(addr[ADDR_W-3:0]);
  assign status_byte = {2'b00, zero_flag, abort_flag, limit_flag, ovf_flag, done, busy};
  // Carry out of the extended sum means the length would exceed its maximum.
  assign olen_sum    = {1'b0, olen} + (OLEN_W+1)'(step_incr);

  always_comb begin
    rd_next = 8'h00;
    case (region)
      REG_ITER: for (int unsigned b = 0; b < NBYTES; b++) if (idx == b) rd_next = iter[8*b +: 8];
      REG_PEAK: for (int unsigned b = 0; b < NBYTES; b++) if (idx == b) rd_next = peak[8*b +: 8];
      REG_OLEN: for (int unsigned b = 0; b < OBYTES; b++) if (idx == b) rd_next = olen[8*b +: 8];
      default:  if (idx == 0) rd_next = status_byte;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      iter       <= '0;
      peak       <= '0;
      olen       <= '0;
      ovf_flag   <= 1'b0;
      limit_flag <= 1'b0;
      abort_flag <= 1'b0;
      zero_flag  <= 1'b0;
      rd_data    <= 8'h00;
    end else begin
      rd_data <= rd_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            olen       <= '0;
            ovf_flag   <= 1'b0;
            limit_flag <= 1'b0;
            abort_flag <= 1'b0;
            zero_flag  <= 1'b0;
            peak       <= iter;
            state      <= RUN;
          end else if (wr_en) begin
            if (region == REG_ITER) begin
              for (int unsigned b = 0; b < NBYTES; b++)
                if (idx == b) iter[8*b +: 8] <= wr_data;
            end
            state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            abort_flag <= 1'b1;
            state      <= IDLE;
          end else if (iter == '0) begin
            zero_flag <= 1'b1;
            state     <= DONE;
          end else if (iter == WIDTH'(1)) begin
            state <= DONE;
          end else if (step_ovf) begin
            ovf_flag <= 1'b1;
            state    <= DONE;
          end else if (olen_sum[OLEN_W]) begin
            limit_flag <= 1'b1;
            state      <= DONE;
          end else begin
            iter <= step_next;
            olen <= olen_sum[OLEN_W-1:0];
            if (step_next > peak) peak <= step_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_orbit_engine.sv
// Directed bench for collatz_orbit_engine across four parameterisations:
// default, shortcut mode, 16-bit iterator and 8-bit orbit length.
module tb_collatz_orbit_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en   [4];
  logic [6:0] addr    [4];
  logic [7:0] wr_data [4];
  logic       start   [4];
  logic       abort   [4];
  logic [7:0] rd_data [4];
  logic       busy    [4];
  logic       done    [4];
  logic       error   [4];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  collatz_orbit_engine u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .addr(addr[0]), .wr_data(wr_data[0]),
    .start(start[0]), .abort(abort[0]), .rd_data(rd_data[0]), .busy(busy[0]),
    .done(done[0]), .error(error[0]));

  collatz_orbit_engine #(.SHORTCUT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .addr(addr[1]), .wr_data(wr_data[1]),
    .start(start[1]), .abort(abort[1]), .rd_data(rd_data[1]), .busy(busy[1]),
    .done(done[1]), .error(error[1]));

  collatz_orbit_engine #(.WIDTH(16)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .addr(addr[2]), .wr_data(wr_data[2]),
    .start(start[2]), .abort(abort[2]), .rd_data(rd_data[2]), .busy(busy[2]),
    .done(done[2]), .error(error[2]));

  collatz_orbit_engine #(.OLEN_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[3]), .addr(addr[3]), .wr_data(wr_data[3]),
    .start(start[3]), .abort(abort[3]), .rd_data(rd_data[3]), .busy(busy[3]),
    .done(done[3]), .error(error[3]));

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input int i, input logic [1:0] reg_sel, input int b, input logic [7:0] d);
    @(negedge clk);
    wr_en[i]   = 1'b1;
    addr[i]    = {reg_sel, 5'(b)};
    wr_data[i] = d;
    @(negedge clk);
    wr_en[i]   = 1'b0;
  endtask

  task automatic write_seed(input int i, input logic [143:0] v, input int nb);
    for (int b = 0; b < nb; b++) write_byte(i, 2'b00, b, v[8*b +: 8]);
  endtask

  task automatic read_byte(input int i, input logic [1:0] reg_sel, input int b, output logic [7:0] d);
    @(negedge clk);
    addr[i] = {reg_sel, 5'(b)};
    @(posedge clk);
    #1;
    d = rd_data[i];
  endtask

  task automatic read_val(input int i, input logic [1:0] reg_sel, input int nb, output logic [143:0] v);
    logic [7:0] d;
    v = '0;
    for (int b = 0; b < nb; b++) begin
      read_byte(i, reg_sel, b, d);
      v[8*b +: 8] = d;
    end
  endtask

  // Returns with the start pulse sampled by exactly one rising edge.
  task automatic start_run(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Counts rising edges after the start edge until done is seen; gives up at max.
  task automatic wait_done(input int i, input int max, output int cycles);
    cycles = 0;
    while (!done[i] && cycles < max) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    logic [143:0] v;
    int cyc;

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en[i] = 1'b0; addr[i] = '0; wr_data[i] = '0; start[i] = 1'b0; abort[i] = 1'b0;
    end
    #23;
    check("reset_rd_data", 144'(rd_data[0]), 144'(0));
    check("reset_busy", 144'(busy[0]), 144'(0));
    check("reset_done", 144'(done[0]), 144'(0));
    check("reset_error", 144'(error[0]), 144'(0));
    @(negedge clk);
    rst_n = 1'b1;
    read_val(0, 2'b11, 1, v);
    check("reset_status", v, 144'(0));

    // Seed 27, plain mode
    write_seed(0, 144'd27, 18);
    read_val(0, 2'b00, 18, v);
    check("seed27_readback", v, 144'd27);
    start_run(0);
    check("seed27_busy", 144'(busy[0]), 144'(1));
    wait_done(0, 300, cyc);
    check("seed27_latency", 144'(cyc), 144'(112));
    read_val(0, 2'b10, 2, v);
    check("seed27_olen", v, 144'd111);
    read_val(0, 2'b01, 18, v);
    check("seed27_peak", v, 144'd9232);
    read_val(0, 2'b11, 1, v);
    check("seed27_status", v, 144'h02);
    check("seed27_error", 144'(error[0]), 144'(0));

    // Seed 27, shortcut mode
    write_seed(1, 144'd27, 18);
    start_run(1);
    wait_done(1, 300, cyc);
    check("sc27_latency", 144'(cyc), 144'(71));
    read_val(1, 2'b10, 2, v);
    check("sc27_olen", v, 144'd111);
    read_val(1, 2'b11, 1, v);
    check("sc27_status", v, 144'h02);

    // Seed 1 then seed 0
    write_seed(0, 144'd1, 18);
    check("write_leaves_done", 144'(done[0]), 144'(0));
    start_run(0);
    wait_done(0, 20, cyc);
    check("seed1_latency", 144'(cyc), 144'(1));
    read_val(0, 2'b10, 2, v);
    check("seed1_olen", v, 144'd0);
    read_val(0, 2'b11, 1, v);
    check("seed1_status", v, 144'h02);
    write_seed(0, 144'd0, 18);
    start_run(0);
    wait_done(0, 20, cyc);
    check("seed0_latency", 144'(cyc), 144'(1));
    read_val(0, 2'b11, 1, v);
    check("seed0_status", v, 144'h22);
    check("seed0_error", 144'(error[0]), 144'(1));

    // 16-bit iterator overflow on 0xFFFF
    write_seed(2, 144'hFFFF, 2);
    start_run(2);
    wait_done(2, 20, cyc);
    check("ovf_latency", 144'(cyc), 144'(1));
    read_val(2, 2'b10, 2, v);
    check("ovf_olen", v, 144'd0);
    read_val(2, 2'b00, 2, v);
    check("ovf_iter", v, 144'hFFFF);
    read_val(2, 2'b11, 1, v);
    check("ovf_status", v, 144'h06);
    read_val(2, 2'b00, 3, v);
    check("ovf_out_of_range_byte", v, 144'hFFFF);

    // 8-bit orbit length: normal then limit (837799 needs 524 steps)
    write_seed(3, 144'd27, 18);
    start_run(3);
    wait_done(3, 300, cyc);
    read_val(3, 2'b10, 2, v);
    check("olen8_seed27_olen", v, 144'd111);
    read_val(3, 2'b11, 1, v);
    check("olen8_seed27_status", v, 144'h02);
    write_seed(3, 144'd837799, 18);
    start_run(3);
    wait_done(3, 600, cyc);
    check("limit_latency", 144'(cyc), 144'(256));
    read_val(3, 2'b10, 2, v);
    check("limit_olen", v, 144'd255);
    read_val(3, 2'b11, 1, v);
    check("limit_status", v, 144'h0A);
    check("limit_error", 144'(error[3]), 144'(1));

    // Abort five cycles after start, with a dropped write during RUN
    write_seed(0, 144'd27, 18);
    start_run(0);
    wr_en[0] = 1'b1; addr[0] = 7'h00; wr_data[0] = 8'hAA;
    @(negedge clk);
    wr_en[0] = 1'b0;
    repeat (3) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort_busy", 144'(busy[0]), 144'(0));
    check("abort_done", 144'(done[0]), 144'(0));
    read_val(0, 2'b10, 2, v);
    check("abort_olen", v, 144'd4);
    read_val(0, 2'b11, 1, v);
    check("abort_status", v, 144'h10);
    check("abort_error", 144'(error[0]), 144'(1));
    read_val(0, 2'b00, 18, v);
    check("abort_iter_write_dropped", v, 144'd62);
    read_val(0, 2'b01, 18, v);
    check("abort_peak", v, 144'd124);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
